// File: rtl/ysyx_25020047_seq_ctrl.sv
// Multi-cycle sequencing controller: fetch, execute settle, optional LSU access
// and writeback, with a per-wait-state watchdog, ebreak halt and retire counter.
module ysyx_25020047_seq_ctrl #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ifu_req_valid,
  input  logic        ifu_req_ready,
  input  logic        ifu_rsp_valid,
  output logic        inst_en,
  input  logic        dec_load,
  input  logic        dec_store,
  input  logic        dec_wen,
  input  logic        dec_ebreak,
  output logic        lsu_req_valid,
  output logic        lsu_req_wen,
  input  logic        lsu_req_ready,
  input  logic        lsu_rsp_valid,
  output logic        rf_wen,
  output logic        pc_wen,
  output logic [31:0] instret,
  output logic        halt,
  output logic        err
);

  typedef enum logic [3:0] {
    S_RESET,
    S_FETCH,
    S_FWAIT,
    S_EXEC,
    S_MEM,
    S_MWAIT,
    S_WB,
    S_HALT,
    S_ERR
  } state_e;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic [31:0] instret_q, instret_d;
  logic        waiting;
  logic        exit_ev;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RESET;
      wait_cnt_q <= '0;
      instret_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      instret_q  <= instret_d;
    end
  end

  always_comb begin
    state_d = state_q;
    waiting = 1'b0;
    exit_ev = 1'b0;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        waiting = 1'b1;
        if (ifu_req_ready) begin
          exit_ev = 1'b1;
          state_d = S_FWAIT;
        end
      end
      S_FWAIT: begin
        waiting = 1'b1;
        if (ifu_rsp_valid) begin
          exit_ev = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (dec_ebreak)                  state_d = S_HALT;
        else if (dec_load || dec_store)  state_d = S_MEM;
        else                             state_d = S_WB;
      end
      S_MEM: begin
        waiting = 1'b1;
        if (lsu_req_ready) begin
          exit_ev = 1'b1;
          state_d = S_MWAIT;
        end
      end
      S_MWAIT: begin
        waiting = 1'b1;
        if (lsu_rsp_valid) begin
          exit_ev = 1'b1;
          state_d = S_WB;
        end
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_RESET;
    endcase

    // An exit event on the expiry cycle takes precedence over the watchdog.
    if (waiting && !exit_ev && (wait_cnt_q == WAIT_LAST)) begin
      state_d = S_ERR;
    end

    if ((state_d != state_q) || !waiting) wait_cnt_d = '0;
    else                                   wait_cnt_d = wait_cnt_q + 16'd1;

    instret_d = instret_q + ((state_q == S_WB) ? 32'd1 : 32'd0);
  end

  always_comb begin
    ifu_req_valid = 1'b0;
    inst_en       = 1'b0;
    lsu_req_valid = 1'b0;
    lsu_req_wen   = 1'b0;
    rf_wen        = 1'b0;
    pc_wen        = 1'b0;
    halt          = 1'b0;
    err           = 1'b0;
    case (state_q)
      S_FETCH: ifu_req_valid = 1'b1;
      S_FWAIT: inst_en = ifu_rsp_valid;
      S_MEM: begin
        lsu_req_valid = 1'b1;
        lsu_req_wen   = dec_store;
      end
      S_WB: begin
        pc_wen = 1'b1;
        rf_wen = dec_wen && !dec_store;
      end
      S_HALT:  halt = 1'b1;
      S_ERR:   err  = 1'b1;
      default: ;
    endcase
  end

  assign instret = instret_q;

endmodule

// File: tb/tb_ysyx_25020047_seq_ctrl.sv
// Scoreboard bench for ysyx_25020047_seq_ctrl: a reactive memory driver, a
// per-instruction outcome model and an independent monitor.
module tb_ysyx_25020047_seq_ctrl;

  localparam int unsigned T = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, inst_en;
  logic        dec_load, dec_store, dec_wen, dec_ebreak;
  logic        lsu_req_valid, lsu_req_wen, lsu_req_ready, lsu_rsp_valid;
  logic        rf_wen, pc_wen, halt, err;
  logic [31:0] instret;

  always #5 clk = ~clk;

  ysyx_25020047_seq_ctrl #(.TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_rsp_valid(ifu_rsp_valid), .inst_en(inst_en),
    .dec_load(dec_load), .dec_store(dec_store), .dec_wen(dec_wen),
    .dec_ebreak(dec_ebreak),
    .lsu_req_valid(lsu_req_valid), .lsu_req_wen(lsu_req_wen),
    .lsu_req_ready(lsu_req_ready), .lsu_rsp_valid(lsu_rsp_valid),
    .rf_wen(rf_wen), .pc_wen(pc_wen), .instret(instret),
    .halt(halt), .err(err)
  );

  // kind: 0 retire, 1 halt, 2 error; lat: cycle index from first FETCH cycle;
  // lsu: observed lsu_req_wen (2 = no data request seen).
  typedef struct {
    int          kind;
    int          lat;
    int          ie;
    int          lsu;
    logic        rf;
    logic [31:0] ir_before;
    logic [31:0] ir_after;
  } exp_t;

  exp_t        sbq[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] model_instret = '0;
  logic [31:0] preload_val = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction kinds: 0 ALU, 1 load, 2 store, 3 ebreak.
  // w = ready-low cycles in FETCH, rsp delay in FWAIT, ready-low in MEM, rsp delay in MWAIT.
  function automatic exp_t predict(input int kind, input bit wen, input int w[4],
                                   input logic [31:0] ir);
    exp_t e;
    int   t;
    bit   mem;
    e.kind = 0; e.lat = 0; e.ie = 0; e.lsu = 2; e.rf = 1'b0;
    e.ir_before = ir; e.ir_after = ir;
    mem = (kind == 1) || (kind == 2);
    t = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        t += 1;
        if (kind == 3) begin
          e.kind = 1; e.lat = t;
          return e;
        end
        if (!mem) break;
        e.lsu = (kind == 2) ? 1 : 0;
      end
      if (w[i] >= int'(T)) begin
        e.kind = 2; e.lat = t + int'(T);
        return e;
      end
      t += w[i] + 1;
      if (i == 1) e.ie = 1;
    end
    e.kind = 0;
    e.lat = t;
    e.rf = wen && (kind != 2);
    e.ir_after = ir + 32'd1;
    return e;
  endfunction

  task automatic quiet_inputs();
    ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0;
    lsu_req_ready = 1'b0; lsu_rsp_valid = 1'b0;
  endtask

  task automatic noise_inputs();
    ifu_req_ready = 1'($urandom_range(0, 1));
    ifu_rsp_valid = 1'($urandom_range(0, 1));
    lsu_req_ready = 1'($urandom_range(0, 1));
    lsu_rsp_valid = 1'($urandom_range(0, 1));
  endtask

  task automatic run_instr(input int kind, input bit wen, input int w[4], input int abort_at,
                           input bit preload, input logic [31:0] pv, output int res);
    exp_t e;
    int   p;
    int   c;
    bit   done;
    if (preload) model_instret = pv;
    e = predict(kind, wen, w, model_instret);
    res = (abort_at >= 0) ? 3 : e.kind;
    if (abort_at < 0) begin
      sbq.push_back(e);
      if (e.kind == 0) model_instret = e.ir_after;
    end
    p = 0; c = 0; done = 1'b0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        dec_load = (kind == 1); dec_store = (kind == 2);
        dec_wen = wen; dec_ebreak = (kind == 3);
        if (preload) begin
          preload_val = pv;
          force dut.instret_q = preload_val;
        end
      end
      if (cyc == 1 && preload) release dut.instret_q;
      if (pc_wen || halt || err) begin
        quiet_inputs();
        done = 1'b1;
      end else begin
        noise_inputs();
        case (p)
          0: if (ifu_req_valid) begin
               if (c >= w[0]) begin ifu_req_ready = 1'b1; p = 1; c = 0; end
               else begin ifu_req_ready = 1'b0; c++; end
             end
          1: if (c >= w[1]) begin ifu_rsp_valid = 1'b1; p = 2; c = 0; end
             else begin ifu_rsp_valid = 1'b0; c++; end
          2: if (lsu_req_valid) begin
               if (c >= w[2]) begin lsu_req_ready = 1'b1; p = 3; c = 0; end
               else begin lsu_req_ready = 1'b0; c++; end
             end
          3: if (abort_at >= 0 && c == abort_at) begin
               quiet_inputs(); rst = 1'b1; done = 1'b1;
             end else if (c >= w[3]) begin lsu_rsp_valid = 1'b1; p = 4; c = 0; end
             else begin lsu_rsp_valid = 1'b0; c++; end
          default: ;
        endcase
      end
    end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL driver_timeout: instruction did not finish within 400 cycles");
    end
  endtask

  task automatic idle_noise(input int n);
    repeat (n) begin
      @(negedge clk);
      noise_inputs();
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    quiet_inputs();
    model_instret = '0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: samples 2 time units after the falling edge.
  initial begin
    bit          rp = 1'b1, rp2 = 1'b1;
    logic        pv_ifu = 1'b0, pv_ifu_rdy = 1'b0, pv_lsu = 1'b0, pv_lsu_rdy = 1'b0;
    logic        ph = 1'b0, pe = 1'b0;
    int          cyc = 0, ie = 0, lsu = 2, kact;
    bit          ir_pend = 1'b0;
    logic [31:0] ir_next = '0, cur = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      #2;
      if (rp) begin
        chk("reset_outputs", 32'({ifu_req_valid, inst_en, lsu_req_valid, lsu_req_wen,
                                  rf_wen, pc_wen, halt, err}), 32'd0);
        chk("reset_instret", instret, 32'd0);
        cur = '0; ir_pend = 1'b0; ph = 1'b0; pe = 1'b0;
      end else begin
        if (rp2) chk("fetch_after_reset", 32'(ifu_req_valid), 32'd1);
        if (ir_pend) begin
          chk("instret_after_wb", instret, ir_next);
          cur = ir_next; ir_pend = 1'b0;
        end
        if (pv_ifu && !pv_ifu_rdy && !err) chk("ifu_req_held", 32'(ifu_req_valid), 32'd1);
        if (pv_lsu && !pv_lsu_rdy && !err) chk("lsu_req_held", 32'(lsu_req_valid), 32'd1);
        if (ifu_req_valid && !pv_ifu) begin cyc = 0; ie = 0; lsu = 2; end
        else cyc++;
        if (inst_en) ie++;
        if (lsu_req_valid) lsu = lsu_req_wen ? 1 : 0;
        if (rf_wen && !pc_wen) chk("rf_wen_outside_wb", 32'(rf_wen), 32'd0);
        if (pc_wen || (halt && !ph) || (err && !pe)) begin
          kact = pc_wen ? 0 : (halt ? 1 : 2);
          if (sbq.size() == 0) begin
            chk("unexpected_event", 32'(kact), 32'hFFFF_FFFF);
          end else begin
            e = sbq.pop_front();
            chk("event_kind", 32'(kact), 32'(e.kind));
            chk("event_latency", 32'(cyc), 32'(e.lat));
            chk("inst_en_count", 32'(ie), 32'(e.ie));
            chk("lsu_req_wen", 32'(lsu), 32'(e.lsu));
            chk("instret_at_event", instret, e.ir_before);
            if (e.kind == 0) begin
              chk("rf_wen", 32'(rf_wen), 32'(e.rf));
              ir_pend = 1'b1; ir_next = e.ir_after;
            end
          end
        end else if (halt || err) begin
          chk("terminal_quiet", 32'({ifu_req_valid, inst_en, lsu_req_valid, rf_wen, pc_wen}), 32'd0);
          chk("terminal_instret", instret, cur);
        end
        ph = halt; pe = err;
      end
      rp2 = rp; rp = rst;
      pv_ifu = ifu_req_valid; pv_ifu_rdy = ifu_req_ready;
      pv_lsu = lsu_req_valid; pv_lsu_rdy = lsu_req_ready;
    end
  end

  initial begin
    int res;
    int kind;
    int w[4];
    int ab;
    bit ok;
    quiet_inputs();
    dec_load = 1'b0; dec_store = 1'b0; dec_wen = 1'b0; dec_ebreak = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    run_instr(0, 1'b1, '{0, 0, 0, 0}, -1, 1'b0, '0, res);
    run_instr(1, 1'b1, '{0, 0, 0, 0}, -1, 1'b0, '0, res);
    run_instr(2, 1'b1, '{0, 0, 0, 0}, -1, 1'b0, '0, res);
    run_instr(0, 1'b1, '{5, 0, 0, 0}, -1, 1'b0, '0, res);
    run_instr(0, 1'b0, '{7, 7, 0, 0}, -1, 1'b0, '0, res);
    run_instr(1, 1'b1, '{0, 1, 7, 7}, -1, 1'b0, '0, res);

    run_instr(0, 1'b1, '{8, 0, 0, 0}, -1, 1'b0, '0, res);
    idle_noise(5); do_reset(2);
    run_instr(2, 1'b0, '{0, 0, 0, 8}, -1, 1'b0, '0, res);
    idle_noise(3); do_reset(2);
    run_instr(1, 1'b1, '{0, 0, 8, 0}, -1, 1'b0, '0, res);
    idle_noise(3); do_reset(2);
    run_instr(0, 1'b1, '{0, 8, 0, 0}, -1, 1'b0, '0, res);
    idle_noise(3); do_reset(2);
    run_instr(3, 1'b1, '{0, 0, 0, 0}, -1, 1'b0, '0, res);
    idle_noise(6); do_reset(2);

    run_instr(0, 1'b1, '{0, 0, 0, 0}, -1, 1'b1, 32'hFFFF_FFFE, res);
    run_instr(1, 1'b1, '{0, 0, 0, 6}, 3, 1'b0, '0, res);
    do_reset(2);
    run_instr(0, 1'b1, '{1, 0, 0, 0}, -1, 1'b1, 32'hFFFF_FFFF, res);
    run_instr(0, 1'b1, '{0, 0, 0, 0}, -1, 1'b0, '0, res);

    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 19);
      kind = (kind < 10) ? 0 : (kind < 14) ? 1 : (kind < 19) ? 2 : 3;
      for (int i = 0; i < 4; i++) begin
        int r;
        r = $urandom_range(0, 19);
        if (r < 15)      w[i] = $urandom_range(0, 2);
        else if (r < 19) w[i] = $urandom_range(3, T - 1);
        else             w[i] = $urandom_range(T, T + 2);
      end
      ab = -1;
      ok = (w[0] < int'(T)) && (w[1] < int'(T)) && (w[2] < int'(T));
      if ((kind == 1 || kind == 2) && ok && w[3] >= 1 && w[3] < int'(T)
          && $urandom_range(0, 9) == 0)
        ab = $urandom_range(0, w[3] - 1);
      run_instr(kind, 1'($urandom_range(0, 1)), w, ab, 1'b0, '0, res);
      if (res == 3) do_reset(2);
      else if (res != 0) begin
        idle_noise($urandom_range(1, 5));
        do_reset($urandom_range(1, 3));
      end
    end

    repeat (5) @(negedge clk);
    #3;
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
